// File: rtl/signed_mac_accumulator.sv
// -----------------------------------------------------------------------------
// signed_mac_accumulator
//   Sequential signed multiply-accumulate engine. After a start pulse it accepts
//   len operand pairs (a, b) over a valid/ready handshake. It sums the full-width
//   signed products into a wide accumulator and then presents one result. The
//   result is held until the consumer accepts it.
//
// Ports
//   clk_i        rising-edge clock
//   rst_i        synchronous active-high reset
//   start_i      begins an operation; only looked at in IDLE
//   len_i        number of terms, captured with start_i
//   in_valid_i   operand pair valid
//   in_ready_o   engine accepts operands this cycle (high only in ACC)
//   a_i, b_i     signed operands
//   out_valid_o  result valid (DONE), held until out_ready_i
//   out_ready_i  consumer accepts result
//   result_o     signed sum of products, OUT_WIDTH bits
//   busy_o       high in every state except IDLE
//   overflow_o   result was clamped (saturating build only, else 0)
//
// Configuration
//   MAC_SATURATE_EN : when defined, the result is clamped to the signed
//   OUT_WIDTH range and overflow_o flags the clamp. When undefined, the result
//   is the low OUT_WIDTH accumulator bits and overflow_o is tied to 0.
// -----------------------------------------------------------------------------
module signed_mac_accumulator #(
  parameter int A_WIDTH   = 16,
  parameter int B_WIDTH   = 16,
  parameter int ACC_WIDTH = 40,
  parameter int OUT_WIDTH = 32,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [CNT_WIDTH-1:0] len_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [A_WIDTH-1:0]   a_i,
  input  logic [B_WIDTH-1:0]   b_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [OUT_WIDTH-1:0] result_o,
  output logic                 busy_o,
  output logic                 overflow_o
);

  localparam int P_WIDTH = A_WIDTH + B_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACC   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t                      state_q,     state_d;
  logic [CNT_WIDTH-1:0]        remaining_q, remaining_d;
  logic signed [P_WIDTH-1:0]   prod_q,      prod_d;
  logic                        prod_vld_q,  prod_vld_d;
  logic signed [ACC_WIDTH-1:0] acc_q,       acc_d;
  logic [OUT_WIDTH-1:0]        result_q,    result_d;
  logic                        overflow_d;

  logic                        beat_s;
  logic signed [P_WIDTH-1:0]   mult_s;
  logic signed [ACC_WIDTH-1:0] prod_ext_s;
  logic [OUT_WIDTH-1:0]        res_from_acc_s;
  logic                        ovf_from_acc_s;

`ifdef MAC_SATURATE_EN
  logic overflow_q;

  // Clamp to the signed OUT_WIDTH range. The value fits exactly when every bit
  // from the accumulator MSB down to bit OUT_WIDTH-1 is equal. Returns {ovf, value}.
  function automatic logic [OUT_WIDTH:0] saturate(input logic [ACC_WIDTH-1:0] v);
    logic [ACC_WIDTH-OUT_WIDTH:0] top;
    top = v[ACC_WIDTH-1:OUT_WIDTH-1];
    if ((top == '0) || (top == '1)) begin
      saturate = {1'b0, v[OUT_WIDTH-1:0]};
    end else if (v[ACC_WIDTH-1]) begin
      saturate = {1'b1, 1'b1, {(OUT_WIDTH-1){1'b0}}};
    end else begin
      saturate = {1'b1, 1'b0, {(OUT_WIDTH-1){1'b1}}};
    end
  endfunction

  assign {ovf_from_acc_s, res_from_acc_s} = saturate(acc_q);
  assign overflow_o = overflow_q;
`else
  assign res_from_acc_s = acc_q[OUT_WIDTH-1:0];
  assign ovf_from_acc_s = 1'b0;
  assign overflow_o     = 1'b0;
`endif

  // Operand handshake and datapath helpers.
  assign beat_s     = in_valid_i && (state_q == ST_ACC);
  assign mult_s     = $signed(a_i) * $signed(b_i);
  assign prod_ext_s = ACC_WIDTH'(prod_q);  // prod_q is signed, so this sign-extends

  // Outputs are decoded from state or taken straight from registers.
  assign in_ready_o  = (state_q == ST_ACC);
  assign out_valid_o = (state_q == ST_DONE);
  assign busy_o      = (state_q != ST_IDLE);
  assign result_o    = result_q;

  // Next-state logic for the FSM and the accumulate pipeline.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    prod_d      = prod_q;
    prod_vld_d  = prod_vld_q;
    acc_d       = acc_q;
    result_d    = result_q;
    overflow_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          acc_d      = '0;
          prod_vld_d = 1'b0;
          if (len_i != '0) begin
            remaining_d = len_i;
            state_d     = ST_ACC;
          end else begin
            result_d = '0;
            state_d  = ST_DONE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACC: begin
        // The product of the previous beat is added in the same cycle that
        // the next product is registered, so back-to-back beats leave no bubble.
        if (prod_vld_q) begin
          acc_d = acc_q + prod_ext_s;
        end else begin
          acc_d = acc_q;
        end
        prod_vld_d = beat_s;
        if (beat_s) begin
          prod_d      = mult_s;
          remaining_d = remaining_q - CNT_WIDTH'(1);
          if (remaining_q == CNT_WIDTH'(1)) begin
            state_d = ST_DRAIN;
          end else begin
            state_d = ST_ACC;
          end
        end else begin
          state_d = ST_ACC;
        end
      end
      ST_DRAIN: begin
        // First DRAIN cycle adds the last product. The second cycle captures the
        // now-final accumulator into the result register.
        if (prod_vld_q) begin
          acc_d      = acc_q + prod_ext_s;
          prod_vld_d = 1'b0;
        end else begin
          result_d   = res_from_acc_s;
          overflow_d = ovf_from_acc_s;
          state_d    = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready_i) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      remaining_q <= '0;
      prod_q      <= '0;
      prod_vld_q  <= 1'b0;
      acc_q       <= '0;
      result_q    <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      prod_q      <= prod_d;
      prod_vld_q  <= prod_vld_d;
      acc_q       <= acc_d;
      result_q    <= result_d;
    end
  end

`ifdef MAC_SATURATE_EN
  // Overflow flag is updated only when the result is captured and held through DONE.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      overflow_q <= 1'b0;
    end else if ((state_q == ST_DRAIN) && !prod_vld_q) begin
      overflow_q <= overflow_d;
    end else if ((state_q == ST_IDLE) && start_i) begin
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= overflow_q;
    end
  end
`else
  logic unused_s;
  assign unused_s = overflow_d;
`endif

endmodule
